// File: rtl/accel_job_driver.sv
// accel_job_driver
//   Host-side job driver for a start/done style accelerator. Takes one operand
//   job at a time from a valid/ready stream and holds it on a registered operand
//   bus. It issues a single-cycle start while the accelerator reports op_ready,
//   then waits for done_next. The result is captured into a one-entry buffer and
//   presented on a valid/ready result stream. A watchdog aborts a job whose
//   accelerator never completes.
//
//   Optional statistics outputs are enabled by defining ACCEL_JOB_DRIVER_STATS_EN.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   job_valid/ready   job stream handshake, job_data = NUM_OPS packed operands
//   op_ready          accelerator idle and able to sample start
//   start             single-cycle start pulse to the accelerator
//   operands          registered operand bus, operand k at [k*DATA_W +: DATA_W]
//   done_next         accelerator completion, result_in valid this cycle
//   result_in         accelerator result
//   res_valid/ready   result stream handshake, res_data = captured result
//   timeout_err       one-cycle pulse on watchdog abort
//   busy              driver not in IDLE
//   job_count, last_latency, err_count   statistics (ACCEL_JOB_DRIVER_STATS_EN)
//
// state | meaning
// IDLE  | no job in flight, may accept a job if the result buffer frees up
// ARM   | operands loaded, waiting for op_ready to issue start
// RUN   | start issued, watchdog counting, waiting for done_next
// DRAIN | watchdog abort, waiting for the accelerator to return to idle

module accel_job_driver #(
    parameter int DATA_W  = 16,
    parameter int NUM_OPS = 4,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [NUM_OPS*DATA_W-1:0] job_data,
    input  logic                      op_ready,
    output logic                      start,
    output logic [NUM_OPS*DATA_W-1:0] operands,
    input  logic                      done_next,
    input  logic [DATA_W-1:0]         result_in,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_data,
`ifdef ACCEL_JOB_DRIVER_STATS_EN
    output logic [15:0]               job_count,
    output logic [15:0]               last_latency,
    output logic [7:0]                err_count,
`endif
    output logic                      timeout_err,
    output logic                      busy
);

    typedef enum logic [1:0] {IDLE, ARM, RUN, DRAIN} state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT - 1);

    state_t      state, state_nx;
    logic [15:0] wd;
    logic        accept;
    logic        capture;

    // rst gating keeps job_ready low while reset is held, even though the
    // state register already reads IDLE.
    assign job_ready = !rst && (state == IDLE) && (!res_valid || res_ready);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx    = state;
        start       = 1'b0;
        timeout_err = 1'b0;
        accept      = 1'b0;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                if (job_valid && job_ready) begin
                    accept   = 1'b1;
                    state_nx = ARM;
                end
            end
            ARM: begin
                if (op_ready) begin
                    start    = 1'b1;
                    state_nx = RUN;
                end
            end
            RUN: begin
                // done_next takes priority over a simultaneous watchdog expiry
                if (done_next) begin
                    capture  = 1'b1;
                    state_nx = IDLE;
                end else if (wd == WD_LAST) begin
                    timeout_err = 1'b1;
                    state_nx    = DRAIN;
                end
            end
            DRAIN: begin
                if (op_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Watchdog sits at zero outside RUN, so it is already clear on RUN entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd <= '0;
        end else if (state == RUN) begin
            wd <= wd + 16'd1;
        end else begin
            wd <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            operands <= '0;
        end else if (accept) begin
            operands <= job_data;
        end
    end

    // Capture only happens in RUN, where the buffer is always empty, so set
    // and clear never compete.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (capture) begin
            res_valid <= 1'b1;
            res_data  <= result_in;
        end else if (res_valid && res_ready) begin
            res_valid <= 1'b0;
        end
    end

`ifdef ACCEL_JOB_DRIVER_STATS_EN
    // Latency counts from the start cycle, i.e. one more than the watchdog.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            job_count    <= '0;
            last_latency <= '0;
            err_count    <= '0;
        end else begin
            if (capture) begin
                last_latency <= wd + 16'd1;
                if (job_count != 16'hFFFF) job_count <= job_count + 16'd1;
            end
            if (timeout_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_accel_job_driver.sv
module tb_accel_job_driver;

    localparam int DATA_W  = 16;
    localparam int NUM_OPS = 4;
    localparam int OPS_W   = DATA_W * NUM_OPS;

    logic             clk = 1'b0;
    logic             rst;
    logic             job_valid;
    logic             job_ready;
    logic [OPS_W-1:0] job_data;
    logic             op_ready;
    logic             start;
    logic [OPS_W-1:0] operands;
    logic             done_next;
    logic [15:0]      result_in;
    logic             res_valid;
    logic             res_ready;
    logic [15:0]      res_data;
    logic             timeout_err;
    logic             busy;
`ifdef ACCEL_JOB_DRIVER_STATS_EN
    logic [15:0]      job_count;
    logic [15:0]      last_latency;
    logic [7:0]       err_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    accel_job_driver #(.DATA_W(DATA_W), .NUM_OPS(NUM_OPS), .TIMEOUT(8)) dut (
        .clk(clk),
        .rst(rst),
        .job_valid(job_valid),
        .job_ready(job_ready),
        .job_data(job_data),
        .op_ready(op_ready),
        .start(start),
        .operands(operands),
        .done_next(done_next),
        .result_in(result_in),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data(res_data),
`ifdef ACCEL_JOB_DRIVER_STATS_EN
        .job_count(job_count),
        .last_latency(last_latency),
        .err_count(err_count),
`endif
        .timeout_err(timeout_err),
        .busy(busy)
    );

    typedef struct {
        logic             jv;
        logic [OPS_W-1:0] jd;
        logic             opr;
        logic             dn;
        logic [15:0]      ri;
        logic             rr;
        logic             e_jr;
        logic             e_st;
        logic             e_rv;
        logic [15:0]      e_rd;
        logic             e_to;
        logic             e_busy;
        logic [OPS_W-1:0] e_ops;
    } vec_t;

    vec_t vq[$];

    localparam logic [OPS_W-1:0] J1 = 64'h0004_0003_0002_0001;
    localparam logic [OPS_W-1:0] J2 = 64'hA0A1_B0B2_C0C3_D0D4;
    localparam logic [OPS_W-1:0] J3 = 64'h1111_2222_3333_4444;
    localparam logic [OPS_W-1:0] J4 = 64'h5555_6666_7777_8888;
    localparam logic [OPS_W-1:0] J5 = 64'h0BAD_0BAD_0BAD_0BAD;
    localparam logic [OPS_W-1:0] J6 = 64'h0006_0005_0004_0003;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic jv, input logic [OPS_W-1:0] jd, input logic opr,
                       input logic dn, input logic [15:0] ri, input logic rr,
                       input logic jr, input logic st, input logic rv, input logic [15:0] rd,
                       input logic to, input logic b, input logic [OPS_W-1:0] ops);
        vec_t v;
        v.jv = jv; v.jd = jd; v.opr = opr; v.dn = dn; v.ri = ri; v.rr = rr;
        v.e_jr = jr; v.e_st = st; v.e_rv = rv; v.e_rd = rd; v.e_to = to;
        v.e_busy = b; v.e_ops = ops;
        vq.push_back(v);
    endtask

    // One clock cycle: drive inputs after the falling edge, settle, return.
    task automatic drive(input logic jv, input logic [OPS_W-1:0] jd, input logic opr,
                         input logic dn, input logic [15:0] ri, input logic rr);
        @(negedge clk);
        job_valid = jv; job_data = jd; op_ready = opr;
        done_next = dn; result_in = ri; res_ready = rr;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        job_valid = 0; job_data = '0; op_ready = 0; done_next = 0; result_in = '0; res_ready = 0;
        rst = 1'b1;
        #1;
        chk("rst.job_ready", job_ready, 0);
        chk("rst.res_valid", res_valid, 0);
        chk("rst.busy", busy, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called right after the start cycle; completes after lat cycles.
    task automatic run_to_result(input int lat, input logic [15:0] r, input string tag);
        for (int k = 1; k < lat; k++) begin
            drive(0, '0, 0, 0, '0, 0);
            chk({tag, ".run_start"}, start, 0);
            chk({tag, ".run_to"}, timeout_err, 0);
            chk({tag, ".run_busy"}, busy, 1);
        end
        drive(0, '0, 0, 1, r, 0);
        chk({tag, ".done_to"}, timeout_err, 0);
        chk({tag, ".done_rv"}, res_valid, 0);
        drive(0, '0, 1, 0, '0, 0);
        chk({tag, ".res_valid"}, res_valid, 1);
        chk({tag, ".res_data"}, res_data, r);
        chk({tag, ".idle"}, busy, 0);
    endtask

    task automatic do_job(input logic [OPS_W-1:0] d, input logic [15:0] r, input int lat,
                          input bit drain, input string tag);
        drive(1, d, 1, 0, '0, 0);
        chk({tag, ".accept_ready"}, job_ready, 1);
        drive(0, '0, 1, 0, '0, 0);
        chk({tag, ".start"}, start, 1);
        chk({tag, ".operands"}, operands, d);
        run_to_result(lat, r, tag);
        if (drain) begin
            drive(0, '0, 1, 0, '0, 1);
            chk({tag, ".drain_ready"}, job_ready, 1);
        end
    endtask

    task automatic do_timeout(input string tag);
        int to_cycle;
        int to_pulses;
        to_cycle = -1;
        to_pulses = 0;
        drive(1, J5, 1, 0, '0, 0);
        chk({tag, ".accept_ready"}, job_ready, 1);
        drive(0, '0, 1, 0, '0, 0);
        chk({tag, ".start"}, start, 1);
        for (int k = 1; k <= 11; k++) begin
            // done_next on the last cycle lands in DRAIN and must be ignored
            drive(0, '0, 0, (k == 11), 16'hDEAD, 0);
            if (timeout_err) begin
                to_pulses++;
                if (to_cycle < 0) to_cycle = k;
            end
            chk({tag, ".no_res_valid"}, res_valid, 0);
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".no_start"}, start, 0);
        end
        chk({tag, ".to_cycle"}, 64'(to_cycle), 64'd8);
        chk({tag, ".to_pulses"}, 64'(to_pulses), 64'd1);
        drive(0, '0, 1, 0, '0, 0);
        chk({tag, ".drain_busy"}, busy, 1);
        chk({tag, ".drain_jr"}, job_ready, 0);
        drive(0, '0, 1, 0, '0, 0);
        chk({tag, ".after_drain_jr"}, job_ready, 1);
        chk({tag, ".after_drain_rv"}, res_valid, 0);
        chk({tag, ".after_drain_busy"}, busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        job_valid = 0; job_data = '0; op_ready = 0; done_next = 0; result_in = '0; res_ready = 0;

        // basic job: accept, start, done_next 7 cycles after start
        add(1, J1, 1, 0, '0, 0,   1, 0, 0, '0, 0, 0, '0);
        add(0, '0, 1, 0, '0, 0,   0, 1, 0, '0, 0, 1, J1);
        for (int i = 0; i < 6; i++)
            add(0, '0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 1, J1);
        add(0, '0, 0, 1, 16'h0015, 0, 0, 0, 0, '0, 0, 1, J1);
        add(0, '0, 1, 0, '0, 0,   0, 0, 1, 16'h0015, 0, 0, J1);
        add(0, '0, 1, 0, '0, 1,   1, 0, 1, 16'h0015, 0, 0, J1);
        add(0, '0, 1, 0, '0, 0,   1, 0, 0, '0, 0, 0, J1);
        // op_ready low for 5 cycles after accept
        add(1, J2, 0, 0, '0, 0,   1, 0, 0, '0, 0, 0, J1);
        for (int i = 0; i < 5; i++)
            add(0, '0, 0, 0, '0, 0, 0, 0, 0, '0, 0, 1, J2);
        add(0, '0, 1, 0, '0, 0,   0, 1, 0, '0, 0, 1, J2);
        add(0, '0, 0, 1, 16'hBEEF, 0, 0, 0, 0, '0, 0, 1, J2);
        add(0, '0, 1, 0, '0, 1,   1, 0, 1, 16'hBEEF, 0, 0, J2);
        add(0, '0, 1, 0, '0, 0,   1, 0, 0, '0, 0, 0, J2);

        apply_reset();
        chk("reset.operands", operands, '0);

        foreach (vq[i]) begin
            drive(vq[i].jv, vq[i].jd, vq[i].opr, vq[i].dn, vq[i].ri, vq[i].rr);
            chk($sformatf("vec%0d.job_ready", i), job_ready, vq[i].e_jr);
            chk($sformatf("vec%0d.start", i), start, vq[i].e_st);
            chk($sformatf("vec%0d.res_valid", i), res_valid, vq[i].e_rv);
            if (vq[i].e_rv) chk($sformatf("vec%0d.res_data", i), res_data, vq[i].e_rd);
            chk($sformatf("vec%0d.timeout_err", i), timeout_err, vq[i].e_to);
            chk($sformatf("vec%0d.busy", i), busy, vq[i].e_busy);
            chk($sformatf("vec%0d.operands", i), operands, vq[i].e_ops);
        end

        // backpressure: result held 10 cycles while a second job waits
        do_job(J3, 16'h1111, 3, 0, "bp1");
        for (int i = 0; i < 10; i++) begin
            drive(1, J4, 1, 0, '0, 0);
            chk("bp.job_ready_low", job_ready, 0);
            chk("bp.res_valid_held", res_valid, 1);
            chk("bp.res_data_held", res_data, 16'h1111);
        end
        drive(1, J4, 1, 0, '0, 1);
        chk("bp.ready_on_handshake", job_ready, 1);
        drive(0, '0, 1, 0, '0, 0);
        chk("bp.second_start", start, 1);
        chk("bp.second_operands", operands, J4);
        chk("bp.buffer_cleared", res_valid, 0);
        run_to_result(4, 16'h2222, "bp2");
        drive(0, '0, 1, 0, '0, 1);
        chk("bp2.drain_ready", job_ready, 1);

        // done_next coinciding with watchdog expiry wins
        do_job(J2, 16'h0808, 8, 1, "edge8");

        do_timeout("to");

        // async reset 3 cycles into RUN
        drive(1, J5, 1, 0, '0, 0);
        drive(0, '0, 1, 0, '0, 0);
        chk("rstrun.start", start, 1);
        for (int k = 0; k < 3; k++) drive(0, '0, 0, 0, '0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstrun.busy", busy, 0);
        chk("rstrun.start", start, 0);
        chk("rstrun.job_ready", job_ready, 0);
        chk("rstrun.res_valid", res_valid, 0);
        chk("rstrun.timeout_err", timeout_err, 0);
        chk("rstrun.operands", operands, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstrel.job_ready", job_ready, 1);
        for (int k = 0; k < 3; k++) begin
            drive(0, '0, 1, 1, 16'h5A5A, 0);
            chk("rstrel.no_start", start, 0);
            chk("rstrel.no_result", res_valid, 0);
            chk("rstrel.idle", busy, 0);
        end
        do_job(J6, 16'h6666, 7, 1, "fresh");

`ifdef ACCEL_JOB_DRIVER_STATS_EN
        apply_reset();
        chk("stats.reset_jobs", job_count, 0);
        chk("stats.reset_errs", err_count, 0);
        do_job(J1, 16'h0015, 7, 1, "s1");
        do_timeout("s_to");
        do_job(J2, 16'h0016, 7, 1, "s2");
        do_job(J3, 16'h0017, 7, 1, "s3");
        chk("stats.job_count", job_count, 3);
        chk("stats.last_latency", last_latency, 7);
        chk("stats.err_count", err_count, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
